// File: rtl/ex_div_if.sv
// Handshake and operand bundle between the execute stage and its divider.
// master: EX side (drives request and operands, observes result/ready).
// slave : divider side (consumes request and operands, drives result/ready).
interface ex_div_if;
  logic        signed_div_i;  // 1 = signed (DIV), 0 = unsigned (DIVU)
  logic [31:0] opdata1_i;     // dividend
  logic [31:0] opdata2_i;     // divisor
  logic        start_i;       // request, held until ready_o is seen
  logic        annul_i;       // abort any in-flight division
  logic [63:0] result_o;      // {remainder -> hi, quotient -> lo}
  logic        ready_o;       // result valid

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Latency: ready_o 33 edges after launch (2 edges for a zero divisor).
// Backpressure: result/ready held while start_i stays high; annul_i aborts at once.
// Ports: clk, rst (sync active-low), div_if (slave: operands, start/annul in;
//        result_o {hi=remainder, lo=quotient}, ready_o out).
module ex_div (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave div_if
);

  typedef enum logic [1:0] {S_FREE, S_BY_ZERO, S_ON, S_END} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] op1_mag, op2_mag;
  logic [32:0] diff;
  logic [31:0] quo_fix, rem_fix;

  // Magnitudes; 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign op1_mag = (div_if.signed_div_i && div_if.opdata1_i[31]) ?
                   (32'd0 - div_if.opdata1_i) : div_if.opdata1_i;
  assign op2_mag = (div_if.signed_div_i && div_if.opdata2_i[31]) ?
                   (32'd0 - div_if.opdata2_i) : div_if.opdata2_i;

  // Trial subtraction of the divisor from the shifted partial remainder; bit 32 is the borrow.
  assign diff = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

  // Sign fix-up: quotient negative when operand signs differ, remainder follows the dividend.
  assign quo_fix = neg_quo_q ? (32'd0 - dividend_q[31:0])  : dividend_q[31:0];
  assign rem_fix = neg_rem_q ? (32'd0 - dividend_q[64:33]) : dividend_q[64:33];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      S_FREE: begin
        if (div_if.start_i && !div_if.annul_i) begin
          neg_quo_d = div_if.signed_div_i && (div_if.opdata1_i[31] ^ div_if.opdata2_i[31]);
          neg_rem_d = div_if.signed_div_i && div_if.opdata1_i[31];
          if (div_if.opdata2_i == 32'd0) begin
            state_d = S_BY_ZERO;
          end else begin
            state_d    = S_ON;
            cnt_d      = 6'd0;
            divisor_d  = op2_mag;
            dividend_d = {32'd0, op1_mag, 1'b0};
          end
        end
      end
      S_BY_ZERO: begin
        // Zero fixes up to zero regardless of the sign flags.
        dividend_d = 65'd0;
        state_d    = S_END;
      end
      S_ON: begin
        if (diff[32]) begin
          dividend_d = {dividend_q[63:0], 1'b0};
        end else begin
          dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_END;
        end
      end
      S_END: begin
        if (!div_if.start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = 64'd0;
        end else begin
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_FREE;
      end
    endcase

    // Abort wins over every other transition, including the last iteration.
    if (div_if.annul_i && (state_q != S_FREE)) begin
      state_d  = S_FREE;
      cnt_d    = 6'd0;
      ready_d  = 1'b0;
      result_d = 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FREE;
      cnt_q      <= 6'd0;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider owned by the execute stage, serving MIPS DIV and DIVU. EX launches a division, holds its stall request until `ready_o`, then forwards `result_o` as the hi/lo pair into the EX/MEM pipeline register (`ex_whilo`/`ex_hi`/`ex_lo`). Radix-2 restoring algorithm, one quotient bit per cycle.

## Interface

Parameters: none (data width fixed at 32).

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with `start_i`
- `opdata1_i`  in  32  dividend; sampled with `start_i`
- `opdata2_i`  in  32  divisor; sampled with `start_i`
- `start_i`  in  1  request; EX holds it high until it observes `ready_o`
- `annul_i`  in  1  abort in-flight division (branch-delay flush or exception)
- `result_o`  out  64  {remainder[63:32] → hi, quotient[31:0] → lo}
- `ready_o`  out  1  result valid

## Operation

- States: FREE, BY_ZERO, ON, END. Counter `cnt` (6 bits), working register `dividend` (65 bits), latched divisor magnitude, latched sign flags.
- FREE:
  - `start_i`=1, `annul_i`=0, divisor==0 → BY_ZERO.
  - `start_i`=1, `annul_i`=0, divisor≠0 → ON, `cnt`=0.
  - When entering ON, latch operand magnitudes: if signed and the operand is negative, use its two's-complement negation, else use it unchanged. The magnitude of 0x80000000 is 0x80000000, treated as unsigned.
  - Initialise `dividend` = {32'b0, |opdata1|, 1'b0}.
  - Otherwise stay in FREE.
- BY_ZERO: → END with quotient = 0, remainder = 0.
- ON, one iteration per cycle:
  - Trial subtract {1'b0, dividend[63:32]} − {1'b0, |divisor|}.
  - On borrow, shift `dividend` left 1 with 0 in bit 0.
  - Otherwise `dividend` = {diff[31:0], dividend[31:0], 1'b1}.
  - `cnt` increments. After the iteration with `cnt`==31, → END.
- Entering END, apply sign fix-up:
  - If signed and sign(op1)≠sign(op2), quotient = −dividend[31:0].
  - If signed and op1 negative, remainder = −dividend[64:33].
  - Otherwise both are used unchanged.
  - Register `result_o` = {remainder, quotient} and set `ready_o`=1.
- END: hold `result_o` and `ready_o`. When `start_i`=0, → FREE with `ready_o`=0 and `result_o`=0.
- `annul_i`=1 in BY_ZERO, ON or END → FREE next cycle, `ready_o`=0, `result_o`=0.
- `start_i`, `opdata*_i` and `signed_div_i` are ignored outside FREE. Operand changes mid-division have no effect.
- Overflow 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0 (wraps, no trap).
- Arithmetic is modulo 2^32 per field. No exceptions are generated.

## Timing

- Reset (`rst`=0 at an edge), from any state including mid-ON: state FREE, `cnt`=0, `ready_o`=0, `result_o`=64'h0.
- Start accepted at edge E (FREE, `start_i`=1):
  - divisor≠0: ON occupies the 32 cycles after E. `ready_o`=1 first visible after edge E+33 (33-cycle latency).
  - divisor==0: BY_ZERO after E. `ready_o`=1 after edge E+2.
- `ready_o` stays high while in END and `start_i` remains 1. It drops on the edge after `start_i` falls.
- Back-to-back: a new `start_i` needs one FREE cycle, so the earliest relaunch is one cycle after leaving END.
- `annul_i` takes priority over every transition in the same cycle, including ON→END on the final iteration.
- `start_i` and `annul_i` high together in FREE: no launch.

## Test plan

- DIVU 100 / 7, start at edge E → `ready_o` rises after E+33, `result_o` = {32'd2, 32'd14}. Drop `start_i` → `ready_o`=0 and `result_o`=0 on the next edge.
- DIV −7 (0xFFFFFFF9) / 2 → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero, DIV 5 / 0 → `ready_o` after E+2, `result_o` = 64'h0.
- 0x80000000 / 0xFFFFFFFF: signed → {0x00000000, 0x80000000}; unsigned → {0x80000000, 0x00000000}. DIVU 0xFFFFFFFF / 1 → {0, 0xFFFFFFFF}.
- Annul while `cnt`==10 → FREE next cycle, `ready_o` never asserts. Immediate new start 9 / 3 → {0, 3} at the correct latency. Annul coinciding with the final iteration → no `ready_o`.
- Reset (`rst`=0) during ON → `ready_o`=0 and `result_o`=0 after the edge. Changing `opdata*_i` mid-ON does not alter the result.
